// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: scan-timing controller and update scheduler for the 640x480@60 VGA path.
// Runs on the master clock and issues a one-clock pixel enable every CE_DIV clocks; no derived
// clock is generated. Sequences the horizontal/vertical counters, the sync/blanking/frame-start
// strobes, and grants game-state update windows only inside vertical blanking.
//
// Ports:
//   clk_i          master clock (50 MHz)
//   rst_ni         asynchronous active-low reset
//   upd_req_i      level request from game logic for an update window
//   pix_ce_o       one-clock pixel enable, every CE_DIV clocks
//   hcount_o       pixel column, 0..H_TOTAL-1
//   vcount_o       line, 0..V_TOTAL-1
//   hsync_o        active-low horizontal sync
//   vsync_o        active-low vertical sync
//   video_on_o     high inside the active picture
//   frame_start_o  one-clock pulse when the counters land on (0,0)
//   upd_gnt_o      update grant, only inside lines V_ACTIVE..V_TOTAL-2
//   frame_count_o  frame counter
//
// Optional feature: define VGA_FRAME_CNT_EN to build the 8-bit frame counter; otherwise
// frame_count_o is tied to zero and no counter register exists.

module vga_scan_ctrl #(
  parameter int unsigned CE_DIV   = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       upd_req_i,
  output logic       pix_ce_o,
  output logic [9:0] hcount_o,
  output logic [9:0] vcount_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       video_on_o,
  output logic       frame_start_o,
  output logic       upd_gnt_o,
  output logic [7:0] frame_count_o
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DivW   = (CE_DIV > 2) ? $clog2(CE_DIV) : 1;

  localparam logic [DivW-1:0] DivLast = DivW'(CE_DIV - 1);

  localparam logic [9:0] HFpStart   = 10'(H_ACTIVE);
  localparam logic [9:0] HSyncStart = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HBpStart   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] HLast      = 10'(HTotal - 1);
  localparam logic [9:0] VFpStart   = 10'(V_ACTIVE);
  localparam logic [9:0] VSyncStart = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VBpStart   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] VLast      = 10'(VTotal - 1);
  // Last line of the frame is a guard line: no grant may be live on it.
  localparam logic [9:0] VGuard     = VLast;
  localparam logic [9:0] VWinLo     = 10'(V_ACTIVE);
  localparam logic [9:0] VWinHi     = 10'(VTotal - 2);

  typedef enum logic [1:0] {HAct, HFp, HSync, HBp} h_state_e;
  typedef enum logic [1:0] {VAct, VFp, VSync, VBp} v_state_e;
  typedef enum logic [1:0] {SchIdle, SchGrant, SchWaitDrop} sch_state_e;

  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic            pix_ce_q, pix_ce_d;
  logic [9:0]      hcount_q, hcount_d;
  logic [9:0]      vcount_q, vcount_d;
  h_state_e        h_state_q, h_state_d;
  v_state_e        v_state_q, v_state_d;
  sch_state_e      sch_q, sch_d;
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic            video_on_q, video_on_d;
  logic            frame_start_q, frame_start_d;
  logic            upd_gnt_q, upd_gnt_d;

  logic h_wrap, v_wrap, in_win_q, in_win_d;

  // Pixel-enable divider and scan counters.
  always_comb begin
    div_cnt_d     = (div_cnt_q == DivLast) ? '0 : div_cnt_q + 1'b1;
    pix_ce_d      = (div_cnt_q == DivLast);
    h_wrap        = (hcount_q == HLast);
    v_wrap        = (vcount_q == VLast);
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    h_state_d     = h_state_q;
    v_state_d     = v_state_q;
    frame_start_d = 1'b0;

    if (pix_ce_q) begin
      hcount_d = h_wrap ? 10'd0 : hcount_q + 10'd1;
      unique case (h_state_q)
        HAct:    if (hcount_d == HFpStart)   h_state_d = HFp;
        HFp:     if (hcount_d == HSyncStart) h_state_d = HSync;
        HSync:   if (hcount_d == HBpStart)   h_state_d = HBp;
        HBp:     if (h_wrap)                 h_state_d = HAct;
        default: h_state_d = HAct;
      endcase

      if (h_wrap) begin
        vcount_d      = v_wrap ? 10'd0 : vcount_q + 10'd1;
        frame_start_d = v_wrap;
        unique case (v_state_q)
          VAct:    if (vcount_d == VFpStart)   v_state_d = VFp;
          VFp:     if (vcount_d == VSyncStart) v_state_d = VSync;
          VSync:   if (vcount_d == VBpStart)   v_state_d = VBp;
          VBp:     if (v_wrap)                 v_state_d = VAct;
          default: v_state_d = VAct;
        endcase
      end
    end

    // Strobes derive from the next state so they move on the same edge as the counters.
    hsync_d    = (h_state_d != HSync);
    vsync_d    = (v_state_d != VSync);
    video_on_d = (h_state_d == HAct) && (v_state_d == VAct);
  end

  // Update scheduler.
  always_comb begin
    // Requiring the next line to be in the window too stops a grant landing on the guard line.
    in_win_q = (vcount_q >= VWinLo) && (vcount_q <= VWinHi);
    in_win_d = (vcount_d >= VWinLo) && (vcount_d <= VWinHi);
    sch_d    = sch_q;
    unique case (sch_q)
      SchIdle:     if (upd_req_i && in_win_q && in_win_d) sch_d = SchGrant;
      SchGrant: begin
        // A drop wins over a simultaneous revoke.
        if (!upd_req_i)                sch_d = SchIdle;
        else if (vcount_d == VGuard)   sch_d = SchWaitDrop;
      end
      SchWaitDrop: if (!upd_req_i) sch_d = SchIdle;
      default:     sch_d = SchIdle;
    endcase
    upd_gnt_d = (sch_d == SchGrant);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt_q     <= '0;
      pix_ce_q      <= 1'b0;
      hcount_q      <= 10'd0;
      vcount_q      <= 10'd0;
      h_state_q     <= HAct;
      v_state_q     <= VAct;
      sch_q         <= SchIdle;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b1;
      frame_start_q <= 1'b0;
      upd_gnt_q     <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      pix_ce_q      <= pix_ce_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      h_state_q     <= h_state_d;
      v_state_q     <= v_state_d;
      sch_q         <= sch_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
      upd_gnt_q     <= upd_gnt_d;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_count_q <= 8'd0;
    end else if (frame_start_d) begin
      frame_count_q <= frame_count_q + 8'd1;
    end
  end

  assign frame_count_o = frame_count_q;
`else
  assign frame_count_o = 8'd0;
`endif

  assign pix_ce_o      = pix_ce_q;
  assign hcount_o      = hcount_q;
  assign vcount_o      = vcount_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign video_on_o    = video_on_q;
  assign frame_start_o = frame_start_q;
  assign upd_gnt_o     = upd_gnt_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench for vga_scan_ctrl. A reduced-geometry instance (34 x 17, CE_DIV=2, so a frame
// is 1156 clocks) exercises frame timing and the scheduler; a default-geometry instance checks
// the 640x480 horizontal timing of one line.
module tb_vga_scan_ctrl;

  // Reduced geometry: H 20/4/6/4 -> 34, V 10/2/2/3 -> 17.
  localparam int FrameClks = 34 * 17 * 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_full_n = 1'b0;
  logic upd_req = 1'b0;
  logic upd_req_f = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic       pix_ce, hsync, vsync, video_on, frame_start, upd_gnt;
  logic [9:0] hcount, vcount;
  logic [7:0] frame_count;

  logic       pix_ce_f, hsync_f, vsync_f, video_on_f, frame_start_f, upd_gnt_f;
  logic [9:0] hcount_f, vcount_f;
  logic [7:0] frame_count_f;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vga_scan_ctrl #(
    .CE_DIV(2), .H_ACTIVE(20), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .upd_req_i(upd_req), .pix_ce_o(pix_ce),
    .hcount_o(hcount), .vcount_o(vcount), .hsync_o(hsync), .vsync_o(vsync),
    .video_on_o(video_on), .frame_start_o(frame_start), .upd_gnt_o(upd_gnt),
    .frame_count_o(frame_count)
  );

  vga_scan_ctrl dut_full (
    .clk_i(clk), .rst_ni(rst_full_n), .upd_req_i(upd_req_f), .pix_ce_o(pix_ce_f),
    .hcount_o(hcount_f), .vcount_o(vcount_f), .hsync_o(hsync_f), .vsync_o(vsync_f),
    .video_on_o(video_on_f), .frame_start_o(frame_start_f), .upd_gnt_o(upd_gnt_f),
    .frame_count_o(frame_count_f)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_hv(input int h, input int v, input string tag);
    int n = 0;
    while (!(int'(hcount) == h && int'(vcount) == v) && n < 4 * FrameClks) begin
      step(1);
      n++;
    end
    check_eq(tag, 32'(n < 4 * FrameClks), 1);
  endtask

  task automatic wait_full_h(input int h, input string tag);
    int n = 0;
    while (int'(hcount_f) != h && n < 4000) begin
      step(1);
      n++;
    end
    check_eq(tag, 32'(n < 4000), 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_pix_ce"}, 32'(pix_ce), 0);
    check_eq({tag, "_hcount"}, 32'(hcount), 0);
    check_eq({tag, "_vcount"}, 32'(vcount), 0);
    check_eq({tag, "_hsync"}, 32'(hsync), 1);
    check_eq({tag, "_vsync"}, 32'(vsync), 1);
    check_eq({tag, "_video_on"}, 32'(video_on), 1);
    check_eq({tag, "_frame_start"}, 32'(frame_start), 0);
    check_eq({tag, "_upd_gnt"}, 32'(upd_gnt), 0);
    check_eq({tag, "_frame_count"}, 32'(frame_count), 0);
  endtask

  initial begin
    int  t0, t1, n;
    logic early, prev_gnt;

    // Reset held with the clock running.
    step(4);
    check_reset_vals("rst");
    check_eq("rst_full_pix_ce", 32'(pix_ce_f), 0);
    check_eq("rst_full_vsync", 32'(vsync_f), 1);
    check_eq("rst_full_frame_start", 32'(frame_start_f), 0);
    check_eq("rst_full_upd_gnt", 32'(upd_gnt_f), 0);
    check_eq("rst_full_frame_count", 32'(frame_count_f), 0);

    // First pix_ce on the 2nd edge after release, then every 2 clocks.
    @(negedge clk);
    rst_n = 1'b1;
    step(1); check_eq("ce_edge1", 32'(pix_ce), 0);
    step(1); check_eq("ce_edge2", 32'(pix_ce), 1);
    check_eq("ce_edge2_hcount", 32'(hcount), 0);
    step(1); check_eq("ce_edge3", 32'(pix_ce), 0);
    check_eq("ce_edge3_hcount", 32'(hcount), 1);
    step(1); check_eq("ce_edge4", 32'(pix_ce), 1);
    check_eq("ce_edge4_hcount", 32'(hcount), 1);

    // Line timing on the reduced geometry.
    wait_hv(19, 0, "wait_h19");
    check_eq("video_on_h19", 32'(video_on), 1);
    wait_hv(20, 0, "wait_h20");
    check_eq("video_on_h20", 32'(video_on), 0);
    wait_hv(23, 0, "wait_h23");
    check_eq("hsync_h23", 32'(hsync), 1);
    wait_hv(24, 0, "wait_h24");
    check_eq("hsync_h24", 32'(hsync), 0);
    t0 = cyc;
    n = 0;
    while (hsync == 1'b0 && n < 200) begin step(1); n++; end
    check_eq("hsync_rise_hcount", 32'(hcount), 30);
    check_eq("hsync_low_clks", 32'(cyc - t0), 12);
    wait_hv(33, 0, "wait_h33");
    step(2);
    check_eq("wrap_hcount", 32'(hcount), 0);
    check_eq("wrap_vcount", 32'(vcount), 1);

    // Deferred grant: request during the active region.
    wait_hv(0, 2, "wait_v2");
    upd_req = 1'b1;
    early = 1'b0;
    n = 0;
    while (int'(vcount) != 10 && n < 2 * FrameClks) begin
      early = early | upd_gnt;
      step(1);
      n++;
    end
    check_eq("defer_no_early_gnt", 32'(early), 0);
    check_eq("defer_gnt_at_entry", 32'(upd_gnt), 0);
    step(1);
    check_eq("defer_gnt_one_clk", 32'(upd_gnt), 1);

    // Vertical sync lines.
    wait_hv(0, 11, "wait_v11");
    check_eq("vsync_v11", 32'(vsync), 1);
    wait_hv(0, 12, "wait_v12");
    check_eq("vsync_v12", 32'(vsync), 0);
    wait_hv(33, 13, "wait_v13");
    check_eq("vsync_v13", 32'(vsync), 0);
    wait_hv(0, 14, "wait_v14");
    check_eq("vsync_v14", 32'(vsync), 1);
    check_eq("gnt_held_v14", 32'(upd_gnt), 1);

    // Forced revoke on the guard line.
    prev_gnt = upd_gnt;
    n = 0;
    while (int'(vcount) != 16 && n < FrameClks) begin
      prev_gnt = upd_gnt;
      step(1);
      n++;
    end
    check_eq("revoke_gnt_before", 32'(prev_gnt), 1);
    check_eq("revoke_gnt_at_guard", 32'(upd_gnt), 0);

    // First frame_start.
    n = 0;
    while (frame_start != 1'b1 && n < 2 * FrameClks) begin step(1); n++; end
    t1 = cyc;
    check_eq("fs1_hcount", 32'(hcount), 0);
    check_eq("fs1_vcount", 32'(vcount), 0);
`ifdef VGA_FRAME_CNT_EN
    check_eq("fs1_frame_count", 32'(frame_count), 1);
`else
    check_eq("fs1_frame_count", 32'(frame_count), 0);
`endif
    step(1);
    check_eq("fs1_one_clk", 32'(frame_start), 0);

    // Request still held since the revoke: no re-grant.
    wait_hv(0, 10, "wait_f1_v10");
    step(3);
    check_eq("no_regrant", 32'(upd_gnt), 0);

    // Second frame_start and period.
    n = 0;
    while (frame_start != 1'b1 && n < 2 * FrameClks) begin step(1); n++; end
    check_eq("fs_period", 32'(cyc - t1), FrameClks);
`ifdef VGA_FRAME_CNT_EN
    check_eq("fs2_frame_count", 32'(frame_count), 2);
`else
    check_eq("fs2_frame_count", 32'(frame_count), 0);
`endif

    // Pulse the request low, then re-grant at the next window.
    wait_hv(0, 3, "wait_f2_v3");
    upd_req = 1'b0;
    step(2);
    upd_req = 1'b1;
    wait_hv(0, 10, "wait_f2_v10");
    check_eq("regrant_at_entry", 32'(upd_gnt), 0);
    step(1);
    check_eq("regrant_one_clk", 32'(upd_gnt), 1);

    // Drop in GRANT.
    wait_hv(0, 11, "wait_f2_v11");
    check_eq("drop_gnt_before", 32'(upd_gnt), 1);
    upd_req = 1'b0;
    step(1);
    check_eq("drop_gnt_one_clk", 32'(upd_gnt), 0);

    // Asynchronous reset mid-frame, between clock edges.
    wait_hv(10, 5, "wait_f3_h10v5");
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    step(1); check_eq("midrst_edge1_ce", 32'(pix_ce), 0);
    step(1); check_eq("midrst_edge2_ce", 32'(pix_ce), 1);
    step(1);
    check_eq("midrst_restart_h", 32'(hcount), 1);
    check_eq("midrst_restart_v", 32'(vcount), 0);

    // Default 640x480 geometry: one line of horizontal timing.
    @(negedge clk);
    rst_full_n = 1'b1;
    wait_full_h(639, "full_wait_h639");
    check_eq("full_video_on_639", 32'(video_on_f), 1);
    wait_full_h(640, "full_wait_h640");
    check_eq("full_video_on_640", 32'(video_on_f), 0);
    wait_full_h(655, "full_wait_h655");
    check_eq("full_hsync_655", 32'(hsync_f), 1);
    wait_full_h(656, "full_wait_h656");
    check_eq("full_hsync_656", 32'(hsync_f), 0);
    t0 = cyc;
    n = 0;
    while (hsync_f == 1'b0 && n < 1000) begin step(1); n++; end
    check_eq("full_hsync_rise_h", 32'(hcount_f), 752);
    check_eq("full_hsync_low_clks", 32'(cyc - t0), 192);
    wait_full_h(799, "full_wait_h799");
    check_eq("full_v_before_wrap", 32'(vcount_f), 0);
    step(2);
    check_eq("full_wrap_h", 32'(hcount_f), 0);
    check_eq("full_wrap_v", 32'(vcount_f), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_scan_ctrl.md
# vga_scan_ctrl

Scan-timing controller and update scheduler for the 640x480@60 VGA path. Runs on the 50 MHz master clock and issues a 25 MHz pixel clock-enable; no derived clock is generated. Sequences the horizontal and vertical counters and the sync, blanking and frame-start strobes. Arbitrates game-state/framebuffer writes so that they fall only inside vertical blanking.

## Interface
Parameters:
- CE_DIV, 2: master clocks per pixel (≥2).
- H_ACTIVE, 640; H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal segments in pixels.
- V_ACTIVE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33: vertical segments in lines.

Ports:
- clk  in  1  master clock, 50 MHz.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- upd_req  in  1  level request from game logic for an update window.
- pix_ce  out  1  one-clk pixel enable, every CE_DIV clks.
- hcount  out  10  pixel column, 0..H_TOTAL-1.
- vcount  out  10  line, 0..V_TOTAL-1.
- hsync  out  1  active-low horizontal sync.
- vsync  out  1  active-low vertical sync.
- video_on  out  1  high when hcount<H_ACTIVE and vcount<V_ACTIVE.
- frame_start  out  1  one-clk pulse on entry to (0,0).
- upd_gnt  out  1  update grant.
- frame_count  out  8  frame counter (see Configuration).

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). All outputs are registered.
- Divider: div_cnt counts 0..CE_DIV-1 and wraps. pix_ce is high in the cycle after div_cnt = CE_DIV-1.
- Horizontal FSM states: H_ACT → H_FP → H_SYNC → H_BP → H_ACT. A transition occurs when hcount crosses a segment boundary.
- Vertical FSM states: V_ACT → V_FP → V_SYNC → V_BP → V_ACT. Advances only on a line wrap.
- hsync is low iff hcount ∈ [656,751]. vsync is low iff vcount ∈ [490,491].
- On a pix_ce edge:
  - hcount increments.
  - At 799, hcount wraps to 0 and vcount increments.
  - At (799,524), both counters wrap to 0, frame_start pulses and frame_count increments mod 256.
- Scheduler states: IDLE, GRANT, WAIT_DROP.
  - Window: vcount ∈ [V_ACTIVE, V_TOTAL-2], i.e. 480..523. Line 524 is a guard line.
  - IDLE → GRANT: upd_req=1 and the position is in the window. upd_gnt rises the next clk.
  - GRANT → IDLE: upd_req=0. upd_gnt falls the next clk.
  - GRANT → WAIT_DROP: vcount reaches 524 while upd_req=1. This is a forced revoke; upd_gnt falls on the same edge vcount becomes 524.
  - WAIT_DROP → IDLE: upd_req=0. No re-grant is given until upd_req has been seen low.
  - upd_req=1 during the active region: stay in IDLE. The grant follows on entry to line 480.
  - upd_req falling and the revoke arriving on the same cycle: go to IDLE.

## Timing
- Reset values (asynchronous, immediate):
  - div_cnt=0, pix_ce=0, hcount=0, vcount=0.
  - hsync=1, vsync=1, video_on=1.
  - frame_start=0, upd_gnt=0, frame_count=0, scheduler IDLE.
- After rst_n rises, the first pix_ce occurs on the CE_DIV-th rising clk edge.
- Counters, syncs and video_on change together on the clk edge where pix_ce=1, and then hold for CE_DIV clks.
- frame_start coincides with the edge on which the counters land on (0,0). It does not fire out of reset.
- Period: frame_start repeats every H_TOTAL·V_TOTAL·CE_DIV = 840000 clks.
- upd_gnt latency is 1 clk after a qualifying upd_req or window entry.
- Reset asserted mid-frame or mid-grant: all state clears immediately. upd_gnt drops with no revoke sequence.

## Configuration
- VGA_FRAME_CNT_EN defined: frame_count is an 8-bit register as described, reset to 0, wrapping 255→0.
- Undefined: frame_count is tied to 8'd0 and no counter register is synthesized. All other behaviour is identical.

## Test plan
- Reset: hold rst_n=0 and toggle clk. Then:
  - Required: all outputs at their reset values.
  - Required: after release, the first pix_ce on the 2nd edge, then every 2 clks.
- Line timing:
  - Required: hsync low for exactly 96 pix_ce (192 clks), starting at hcount=656.
  - Required: hcount goes 799→0 with vcount+1.
  - Required: video_on falls at hcount=640.
- Frame timing:
  - Required: vsync low for lines 490–491 only.
  - Required: frame_start pulses are 840000 clks apart.
  - Required (with VGA_FRAME_CNT_EN): frame_count goes 0→1→2.
- Deferred grant: upd_req=1 at vcount=100.
  - Required: upd_gnt=0 until vcount becomes 480, then 1 exactly one clk later.
- Revoke and drop: hold upd_req through line 524.
  - Required: upd_gnt falls at vcount=524.
  - Required: no re-grant at the next 480 until upd_req has pulsed low.
  - Required: upd_req=0 in GRANT drops upd_gnt in 1 clk.
- Async reset mid-frame at (300,200) with upd_gnt=0:
  - Required: immediate reset values.
  - Required: the counter sequence restarts from (0,0).
